pipe_ctrl: RTL and testbench

Central pipeline control block for the five-stage core. It drives the `load`/`clear` pairs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. Those registers all clear synchronously with priority over load. From decode and execute information it generates stalls for load-use hazards, flushes for taken branches, multi-cycle freezes for the iterative multiplier, and global holds for memory wait states. It also keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/pipe_ctrl_hazard_detect.sv | 22 ++
 rtl/pipe_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default constants for the pipeline control block.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_e;

  localparam int unsigned DefAddrWidth  = 5;
  localparam int unsigned DefMulLatency = 4;
  localparam int unsigned DefCntWidth   = 16;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use hazard comparator between the ID and EX stages.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned AddrWidth = DefAddrWidth
) (
  input  logic [AddrWidth-1:0] id_rs,
  input  logic [AddrWidth-1:0] id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic                 ex_memread,
  input  logic [AddrWidth-1:0] ex_rd,
  output logic                 load_use
);

  always_comb begin
    load_use = ex_memread && (ex_rd != '0) &&
               ((id_uses_rs && (id_rs == ex_rd)) ||
                (id_uses_rt && (id_rt == ex_rd)));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: load-use stalls, branch flushes, multiply freezes,
// memory holds and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned AddrWidth  = DefAddrWidth,
  parameter int unsigned MulLatency = DefMulLatency,
  parameter int unsigned CntWidth   = DefCntWidth
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [AddrWidth-1:0] id_rs,
  input  logic [AddrWidth-1:0] id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic                 ex_memread,
  input  logic [AddrWidth-1:0] ex_rd,
  input  logic                 ex_branch_taken,
  input  logic                 ex_is_mul,
  input  logic                 mem_hold,
  output logic                 load_pc,
  output logic                 load_ifid,
  output logic                 load_idex,
  output logic                 load_exmem,
  output logic                 load_memwb,
  output logic                 clear_ifid,
  output logic                 clear_idex,
  output logic                 clear_exmem,
  output logic                 clear_memwb,
  output logic                 mul_busy,
  output logic [CntWidth-1:0]  stall_cycles
);

  localparam int unsigned CntBits = $clog2(MulLatency);
  localparam logic [CntBits-1:0] MulReload = CntBits'(MulLatency - 2);

  state_e              state_q, state_d;
  logic [CntBits-1:0]  cnt_q, cnt_d;
  logic [CntWidth-1:0] stall_q, stall_d;
  logic                load_use;

  hazard_detect #(
    .AddrWidth(AddrWidth)
  ) u_hazard_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .load_use   (load_use)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  // Priority chain: reset, mem_hold, multiply freeze, branch, load-use.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_pc     = 1'b1;
    load_ifid   = 1'b1;
    load_idex   = 1'b1;
    load_exmem  = 1'b1;
    load_memwb  = 1'b1;
    clear_ifid  = 1'b0;
    clear_idex  = 1'b0;
    clear_exmem = 1'b0;
    clear_memwb = 1'b0;

    if (reset) begin
      {load_pc, load_ifid, load_idex, load_exmem, load_memwb} = '0;
      {clear_ifid, clear_idex, clear_exmem, clear_memwb}      = '1;
    end else if (mem_hold) begin
      {load_pc, load_ifid, load_idex, load_exmem, load_memwb} = '0;
    end else if (state_q == MUL_WAIT) begin
      if (cnt_q != '0) begin
        {load_pc, load_ifid, load_idex} = '0;
        clear_exmem = 1'b1;
        cnt_d       = cnt_q - CntBits'(1);
      end else begin
        state_d = RUN;
      end
    end else if (ex_is_mul) begin
      {load_pc, load_ifid, load_idex} = '0;
      clear_exmem = 1'b1;
      state_d     = MUL_WAIT;
      cnt_d       = MulReload;
    end else if (ex_branch_taken) begin
      clear_ifid = 1'b1;
      clear_idex = 1'b1;
    end else if (load_use) begin
      load_pc    = 1'b0;
      load_ifid  = 1'b0;
      clear_idex = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!mem_hold && !load_pc && (stall_q != '1)) begin
      stall_d = stall_q + CntWidth'(1);
    end
  end

  assign mul_busy     = (state_q == MUL_WAIT);
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed vector bench for pipe_ctrl: stall, flush, freeze, hold, reset, saturation.
module tb_pipe_ctrl;

  localparam logic [8:0] DEF  = 9'b11111_0000;
  localparam logic [8:0] LU   = 9'b00111_0100;
  localparam logic [8:0] BR   = 9'b11111_1100;
  localparam logic [8:0] FZ   = 9'b00011_0010;
  localparam logic [8:0] HOLD = 9'b00000_0000;
  localparam logic [8:0] RST  = 9'b00000_1111;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        urs;
    logic        urt;
    logic        memrd;
    logic [4:0]  rd;
    logic        br;
    logic        mul;
    logic        hold;
    logic [8:0]  ctl;
    logic        busy;
    logic [15:0] stall;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rd = '0;
  logic        id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_memread = 1'b0;
  logic        ex_branch_taken = 1'b0, ex_is_mul = 1'b0, mem_hold = 1'b0;

  logic        load_pc, load_ifid, load_idex, load_exmem, load_memwb;
  logic        clear_ifid, clear_idex, clear_exmem, clear_memwb;
  logic        mul_busy;
  logic [15:0] stall_cycles;

  logic        s_load_pc, s_load_ifid, s_load_idex, s_load_exmem, s_load_memwb;
  logic        s_clear_ifid, s_clear_idex, s_clear_exmem, s_clear_memwb;
  logic        s_mul_busy;
  logic [3:0]  s_stall_cycles;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  vec_t        tbl[22];

  always #5 clock = ~clock;

  pipe_ctrl #(.AddrWidth(5), .MulLatency(4), .CntWidth(16)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ex_is_mul(ex_is_mul), .mem_hold(mem_hold),
    .load_pc(load_pc), .load_ifid(load_ifid), .load_idex(load_idex),
    .load_exmem(load_exmem), .load_memwb(load_memwb),
    .clear_ifid(clear_ifid), .clear_idex(clear_idex),
    .clear_exmem(clear_exmem), .clear_memwb(clear_memwb),
    .mul_busy(mul_busy), .stall_cycles(stall_cycles)
  );

  // Narrow counter instance so saturation is reachable in a few cycles.
  pipe_ctrl #(.AddrWidth(5), .MulLatency(4), .CntWidth(4)) dut_sat (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ex_is_mul(ex_is_mul), .mem_hold(mem_hold),
    .load_pc(s_load_pc), .load_ifid(s_load_ifid), .load_idex(s_load_idex),
    .load_exmem(s_load_exmem), .load_memwb(s_load_memwb),
    .clear_ifid(s_clear_ifid), .clear_idex(s_clear_idex),
    .clear_exmem(s_clear_exmem), .clear_memwb(s_clear_memwb),
    .mul_busy(s_mul_busy), .stall_cycles(s_stall_cycles)
  );

  always @(negedge clock) begin
    if (!reset && ex_is_mul && ex_branch_taken)
      $error("ex_is_mul and ex_branch_taken asserted together");
  end

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic memrd,
                              input logic [4:0] rd, input logic br, input logic mul,
                              input logic hold, input logic [8:0] ctl,
                              input logic busy, input logic [15:0] stall);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.memrd = memrd;
    v.rd = rd; v.br = br; v.mul = mul; v.hold = hold;
    v.ctl = ctl; v.busy = busy; v.stall = stall;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
    ex_memread = v.memrd; ex_rd = v.rd; ex_branch_taken = v.br;
    ex_is_mul = v.mul; mem_hold = v.hold;
  endtask

  function automatic logic [8:0] ctl_now();
    return {load_pc, load_ifid, load_idex, load_exmem, load_memwb,
            clear_ifid, clear_idex, clear_exmem, clear_memwb};
  endfunction

  initial begin
    //          rs rt urs urt mr rd br mul hold ctl  busy stall
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  0, 0);
    tbl[1]  = mk(5, 0, 1, 0, 1, 5, 0, 0, 0, LU,   0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  0, 1);
    tbl[3]  = mk(0, 7, 0, 1, 1, 7, 0, 0, 0, LU,   0, 1);
    tbl[4]  = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, DEF,  0, 2);
    tbl[5]  = mk(5, 0, 0, 0, 1, 5, 0, 0, 0, DEF,  0, 2);
    tbl[6]  = mk(5, 0, 1, 0, 1, 5, 1, 0, 0, BR,   0, 2);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FZ,   0, 2);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FZ,   1, 3);
    tbl[9]  = mk(5, 0, 1, 0, 1, 5, 0, 1, 0, FZ,   1, 4);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, DEF,  1, 5);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FZ,   0, 5);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FZ,   1, 6);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, HOLD, 1, 7);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, HOLD, 1, 7);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FZ,   1, 7);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, DEF,  1, 8);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  0, 8);
    tbl[18] = mk(5, 0, 1, 0, 1, 5, 0, 0, 1, HOLD, 0, 8);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  0, 8);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FZ,   0, 8);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, FZ,   1, 9);

    @(negedge clock);
    chk("reset_ctl",   32'(ctl_now()), 32'(RST));
    chk("reset_busy",  32'(mul_busy), 32'd0);
    chk("reset_stall", 32'(stall_cycles), 32'd0);

    for (int unsigned i = 0; i < 22; i++) begin
      @(posedge clock);
      #1;
      reset = 1'b0;
      drive(tbl[i]);
      @(negedge clock);
      chk($sformatf("row%0d_ctl", i),   32'(ctl_now()), 32'(tbl[i].ctl));
      chk($sformatf("row%0d_busy", i),  32'(mul_busy), 32'(tbl[i].busy));
      chk($sformatf("row%0d_stall", i), 32'(stall_cycles), 32'(tbl[i].stall));
    end

    // Reset arriving in MUL_WAIT acts asynchronously.
    @(posedge clock);
    #1;
    chk("pre_reset_busy", 32'(mul_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("midmul_reset_ctl",   32'(ctl_now()), 32'(RST));
    chk("midmul_reset_busy",  32'(mul_busy), 32'd0);
    chk("midmul_reset_stall", 32'(stall_cycles), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset_ctl",   32'(ctl_now()), 32'(DEF));
    chk("post_reset_busy",  32'(mul_busy), 32'd0);
    chk("post_reset_stall", 32'(stall_cycles), 32'd0);

    // Continuous load-use: one stall counted per edge until saturation.
    id_rs = 5'd9; id_uses_rs = 1'b1; ex_memread = 1'b1; ex_rd = 5'd9;
    repeat (14) @(posedge clock);
    #1;
    chk("sat_preset_narrow", 32'(s_stall_cycles), 32'hE);
    chk("sat_preset_wide",   32'(stall_cycles), 32'd14);
    repeat (3) @(posedge clock);
    #1;
    chk("sat_narrow", 32'(s_stall_cycles), 32'hF);
    chk("sat_wide",   32'(stall_cycles), 32'd17);
    chk("sat_ctl",    32'(ctl_now()), 32'(LU));

    id_uses_rs = 1'b0; ex_memread = 1'b0;
    @(negedge clock);
    chk("final_ctl", 32'(ctl_now()), 32'(DEF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
